// File: rtl/rgb565_grayscale_stream_if.sv
// Valid/ready stream bundle for the RGB565-to-grayscale converter: pixel input side and packed gray output side.
// The slave modport is the converter's view; master is the surrounding source/sink.
interface rgb565_grayscale_stream_if #(
  parameter int PIX_IN = 2,
  parameter int PACK   = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [16*PIX_IN-1:0]      in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [8*PIX_IN*PACK-1:0]  out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/rgb565_grayscale_stream.sv
// Streaming RGB565 to 8-bit grayscale converter that packs PACK input beats into one output word.
// Optional macro GRAYSCALE_ROUND_EN selects round-half-up instead of truncation of the weighted sum.
module rgb565_grayscale_stream #(
  parameter int PIX_IN = 2,
  parameter int PACK   = 2,
  parameter int COEF_R = 54,
  parameter int COEF_G = 183,
  parameter int COEF_B = 19
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  rgb565_grayscale_stream_if.slave   bus
);

  localparam int BEAT_W = 8 * PIX_IN;
  localparam int WORD_W = BEAT_W * PACK;
  localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

  logic [IDX_W-1:0]             beatIdxQ, beatIdxD;
  logic [PACK-1:0][BEAT_W-1:0]  packQ, packD;
  logic                         outValidQ, outValidD;
  logic [WORD_W-1:0]            outDataQ, outDataD;

  logic [BEAT_W-1:0]            curBytes;
  logic [PACK-1:0][BEAT_W-1:0]  wordD;
  logic                         lastBeat;
  logic                         inReady;
  logic                         accept;
  logic                         finalAccept;

  // Channels are widened by replicating their MSBs so full-scale input maps to 255.
  function automatic logic [7:0] toGray(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    sum = 16'(COEF_R * int'(r8) + COEF_G * int'(g8) + COEF_B * int'(b8));
`ifdef GRAYSCALE_ROUND_EN
    sum = sum + 16'd128;
`else
`endif
    return sum[15:8];
  endfunction

  always_comb begin
    curBytes = '0;
    for (int p = 0; p < PIX_IN; p++) begin
      curBytes[8*p +: 8] = toGray(bus.in_data[16*p +: 16]);
    end
  end

  // Only the final beat of a word can be blocked; earlier beats land in pack storage.
  always_comb begin
    lastBeat    = (beatIdxQ == LAST_IDX);
    inReady     = !clear && !(lastBeat && outValidQ && !bus.out_ready);
    accept      = bus.in_valid && inReady;
    finalAccept = accept && lastBeat;
  end

  always_comb begin
    wordD = packQ;
    for (int b = 0; b < PACK; b++) begin
      if (IDX_W'(b) == beatIdxQ) begin
        wordD[b] = curBytes;
      end
    end
  end

  // Clear only touches the partial word; a held output keeps draining.
  always_comb begin
    beatIdxD  = beatIdxQ;
    packD     = packQ;
    outValidD = outValidQ;
    outDataD  = outDataQ;

    if (clear) begin
      beatIdxD = '0;
      packD    = '0;
    end else if (accept) begin
      if (lastBeat) begin
        beatIdxD = '0;
      end else begin
        beatIdxD        = beatIdxQ + 1'b1;
        packD[beatIdxQ] = curBytes;
      end
    end

    if (finalAccept) begin
      outValidD = 1'b1;
      outDataD  = wordD;
    end else if (outValidQ && bus.out_ready) begin
      outValidD = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beatIdxQ  <= '0;
      packQ     <= '0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else begin
      beatIdxQ  <= beatIdxD;
      packQ     <= packD;
      outValidQ <= outValidD;
      outDataQ  <= outDataD;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValidQ;
  assign bus.out_data  = outDataQ;

endmodule
